// File: rtl/led_phase_scheduler_pkg.sv
// Shared state encoding, default timing parameters and front-end field widths
// for the LED phase scheduler.
package led_phase_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AMB  = 2'd1,
        ST_RED  = 2'd2,
        ST_IR   = 2'd3
    } state_t;

    localparam int unsigned SETTLE_DEF   = 2;
    localparam int unsigned AVG_LOG2_DEF = 3;
    localparam int unsigned ADC_W        = 8;
    localparam int unsigned PGA_W        = 4;
    localparam int unsigned DC_W         = 7;

endpackage

// File: rtl/led_phase_scheduler_phase_averager.sv
// Accumulates post-settle ADC samples of one phase and offers the truncated
// mean, including the sample present on the final cycle.
module phase_averager
    import led_phase_scheduler_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_en_i,
    input  logic             last_i,
    input  logic [ADC_W-1:0] adc_i,
    output logic [ADC_W-1:0] avg_o
);

    localparam int unsigned ACC_W = ADC_W + AVG_LOG2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    // 2^AVG_LOG2 samples of at most 255 always fit in ACC_W bits.
    always_comb begin
        sum   = acc_q + ACC_W'(adc_i);
        avg_o = ADC_W'(sum >> AVG_LOG2);
        acc_d = acc_q;
        if (sample_en_i) begin
            acc_d = last_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/led_phase_scheduler.sv
// Sequences ambient / red / IR measurement phases, drives the LED and analog
// front-end settings, and publishes one averaged result triple per frame.
module led_phase_scheduler
    import led_phase_scheduler_pkg::*;
#(
    parameter int unsigned SETTLE   = SETTLE_DEF,
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             enable,
    input  logic [ADC_W-1:0] ADC,
    input  logic [PGA_W-1:0] cfg_red_pga,
    input  logic [PGA_W-1:0] cfg_ir_pga,
    input  logic [DC_W-1:0]  cfg_red_dc,
    input  logic [DC_W-1:0]  cfg_ir_dc,
    input  logic             out_ready,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [ADC_W-1:0] AMB_ADC_Value,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic             out_valid,
    output logic             overrun
);

    localparam int unsigned PHASE_LEN = SETTLE + (1 << AVG_LOG2);
    localparam int unsigned CNT_W     = $clog2(PHASE_LEN);

    state_t             state_q;
    logic [CNT_W-1:0]   phase_cnt_q;
    logic [PGA_W-1:0]   sh_red_pga_q, sh_ir_pga_q;
    logic [DC_W-1:0]    sh_red_dc_q, sh_ir_dc_q;
    logic [ADC_W-1:0]   amb_res_q, red_res_q;
    logic               led_red_q, led_ir_q;
    logic [PGA_W-1:0]   pga_q;
    logic [DC_W-1:0]    dc_q;
    logic [ADC_W-1:0]   amb_out_q, red_out_q, ir_out_q;
    logic               out_valid_q, overrun_q;

    logic               active;
    logic               last;
    logic               sample_en;
    logic [ADC_W-1:0]   avg;

    assign active    = (state_q != ST_IDLE);
    assign last      = active && (phase_cnt_q == CNT_W'(PHASE_LEN - 1));
    assign sample_en = active && (phase_cnt_q >= CNT_W'(SETTLE));

    phase_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk_i       (CLK),
        .rst_i       (rst),
        .sample_en_i (sample_en),
        .last_i      (last),
        .adc_i       (ADC),
        .avg_o       (avg)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_cnt_q  <= '0;
            sh_red_pga_q <= '0;
            sh_ir_pga_q  <= '0;
            sh_red_dc_q  <= '0;
            sh_ir_dc_q   <= '0;
            amb_res_q    <= '0;
            red_res_q    <= '0;
            led_red_q    <= 1'b0;
            led_ir_q     <= 1'b0;
            pga_q        <= '0;
            dc_q         <= '0;
            amb_out_q    <= '0;
            red_out_q    <= '0;
            ir_out_q     <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // Consumer handshake; an IR-end reload below may re-assert on the same edge.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            phase_cnt_q <= last ? '0 : phase_cnt_q + CNT_W'(1);
            unique case (state_q)
                ST_IDLE: begin
                    phase_cnt_q <= '0;
                    if (enable) begin
                        state_q      <= ST_AMB;
                        sh_red_pga_q <= cfg_red_pga;
                        sh_ir_pga_q  <= cfg_ir_pga;
                        sh_red_dc_q  <= cfg_red_dc;
                        sh_ir_dc_q   <= cfg_ir_dc;
                    end
                end
                ST_AMB: begin
                    if (last) begin
                        state_q   <= ST_RED;
                        amb_res_q <= avg;
                        led_red_q <= 1'b1;
                        pga_q     <= sh_red_pga_q;
                        dc_q      <= sh_red_dc_q;
                    end
                end
                ST_RED: begin
                    if (last) begin
                        state_q   <= ST_IR;
                        red_res_q <= avg;
                        led_red_q <= 1'b0;
                        led_ir_q  <= 1'b1;
                        pga_q     <= sh_ir_pga_q;
                        dc_q      <= sh_ir_dc_q;
                    end
                end
                ST_IR: begin
                    if (last) begin
                        led_ir_q <= 1'b0;
                        pga_q    <= '0;
                        dc_q     <= '0;
                        if (!out_valid_q || out_ready) begin
                            amb_out_q   <= amb_res_q;
                            red_out_q   <= red_res_q;
                            ir_out_q    <= avg;
                            out_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        if (enable) begin
                            state_q      <= ST_AMB;
                            sh_red_pga_q <= cfg_red_pga;
                            sh_ir_pga_q  <= cfg_ir_pga;
                            sh_red_dc_q  <= cfg_red_dc;
                            sh_ir_dc_q   <= cfg_ir_dc;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LED_RED       = led_red_q;
    assign LED_IR        = led_ir_q;
    assign PGA_Gain      = pga_q;
    assign DC_Comp       = dc_q;
    assign AMB_ADC_Value = amb_out_q;
    assign RED_ADC_Value = red_out_q;
    assign IR_ADC_Value  = ir_out_q;
    assign out_valid     = out_valid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Directed-vector bench for led_phase_scheduler with default parameters:
// one frame is 30 cycles (AMB, RED, IR, 10 cycles each).
module tb_led_phase_scheduler;
    import led_phase_scheduler_pkg::*;

    logic       CLK = 1'b0;
    logic       rst, enable, out_ready;
    logic [7:0] ADC;
    logic [3:0] cfg_red_pga, cfg_ir_pga;
    logic [6:0] cfg_red_dc, cfg_ir_dc;
    logic       LED_RED, LED_IR, out_valid, overrun;
    logic [3:0] PGA_Gain;
    logic [6:0] DC_Comp;
    logic [7:0] AMB_ADC_Value, RED_ADC_Value, IR_ADC_Value;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] vec [30];
    logic       next_en;
    int         chg_at;
    logic [3:0] chg_val;
    logic [3:0] exp_red_pga;

    led_phase_scheduler dut (
        .CLK           (CLK),
        .rst           (rst),
        .enable        (enable),
        .ADC           (ADC),
        .cfg_red_pga   (cfg_red_pga),
        .cfg_ir_pga    (cfg_ir_pga),
        .cfg_red_dc    (cfg_red_dc),
        .cfg_ir_dc     (cfg_ir_dc),
        .out_ready     (out_ready),
        .LED_RED       (LED_RED),
        .LED_IR        (LED_IR),
        .PGA_Gain      (PGA_Gain),
        .DC_Comp       (DC_Comp),
        .AMB_ADC_Value (AMB_ADC_Value),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .out_valid     (out_valid),
        .overrun       (overrun)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] r, input logic [7:0] i);
        for (int k = 0; k < 10; k++) begin
            vec[k]      = a;
            vec[10 + k] = r;
            vec[20 + k] = i;
        end
    endtask

    // Drives one full frame starting in the first AMB cycle; leaves the bench
    // in the cycle right after the IR-end edge.
    task automatic run_frame();
        for (int i = 0; i < 30; i++) begin
            ADC = vec[i];
            if (i == chg_at) cfg_red_pga = chg_val;
            if (i == 29) enable = next_en;
            if (i == 0) begin
                chk("amb_led_red", 32'(LED_RED), 32'd0);
                chk("amb_led_ir",  32'(LED_IR),  32'd0);
                chk("amb_pga",     32'(PGA_Gain), 32'd0);
                chk("amb_dc",      32'(DC_Comp),  32'd0);
            end
            if (i == 10 || i == 19) begin
                chk("red_led_red", 32'(LED_RED), 32'd1);
                chk("red_led_ir",  32'(LED_IR),  32'd0);
                chk("red_pga",     32'(PGA_Gain), 32'(exp_red_pga));
                chk("red_dc",      32'(DC_Comp),  32'd33);
            end
            if (i == 20) begin
                chk("ir_led_red", 32'(LED_RED), 32'd0);
                chk("ir_led_ir",  32'(LED_IR),  32'd1);
                chk("ir_pga",     32'(PGA_Gain), 32'd7);
                chk("ir_dc",      32'(DC_Comp),  32'd44);
            end
            step();
        end
    endtask

    task automatic chk_vals(input string tag, input logic [7:0] a, input logic [7:0] r, input logic [7:0] i);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_amb"},   32'(AMB_ADC_Value), 32'(a));
        chk({tag, "_red"},   32'(RED_ADC_Value), 32'(r));
        chk({tag, "_ir"},    32'(IR_ADC_Value),  32'(i));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; out_ready = 1'b1; ADC = 8'd0;
        cfg_red_pga = 4'd5; cfg_ir_pga = 4'd7; cfg_red_dc = 7'd33; cfg_ir_dc = 7'd44;
        next_en = 1'b0; chg_at = -1; chg_val = 4'd0; exp_red_pga = 4'd5;
        step(); step();
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_overrun", 32'(overrun),   32'd0);
        chk("rst_led",     32'({LED_RED, LED_IR}), 32'd0);
        chk("rst_vals",    32'({AMB_ADC_Value, RED_ADC_Value, IR_ADC_Value}), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Constant per-phase levels
        fill(8'd20, 8'd200, 8'd150);
        enable = 1'b1; step();
        run_frame();
        chk_vals("const", 8'd20, 8'd200, 8'd150);
        step();
        chk("const_clear", 32'(out_valid), 32'd0);
        chk("const_idle",  32'(dut.state_q), 32'(ST_IDLE));

        // Settling cycles must be discarded
        for (int k = 0; k < 30; k++) vec[k] = ((k % 10) < 2) ? 8'd255 : 8'd100;
        enable = 1'b1; step();
        run_frame();
        chk_vals("settle", 8'd100, 8'd100, 8'd100);
        step();

        // Truncating average: RED 0..7 sums to 28 -> 3
        fill(8'd0, 8'd0, 8'd8);
        vec[10] = 8'd255; vec[11] = 8'd255;
        for (int k = 0; k < 8; k++) vec[12 + k] = 8'(k);
        enable = 1'b1; step();
        run_frame();
        chk_vals("trunc", 8'd0, 8'd3, 8'd8);
        step();

        // Backpressure over two frames with mid-frame config change
        out_ready = 1'b0;
        fill(8'd10, 8'd11, 8'd12);
        chg_at = 15; chg_val = 4'd9; next_en = 1'b1;
        enable = 1'b1; step();
        run_frame();
        chk_vals("bp1", 8'd10, 8'd11, 8'd12);
        chk("bp1_overrun", 32'(overrun), 32'd0);
        fill(8'd30, 8'd31, 8'd32);
        chg_at = -1; exp_red_pga = 4'd9; next_en = 1'b0;
        run_frame();
        chk_vals("bp2", 8'd10, 8'd11, 8'd12);
        chk("bp2_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_clear",   32'(out_valid), 32'd0);
        chk("bp_sticky",  32'(overrun),   32'd1);

        // Reset in RED at phase_cnt = 4
        fill(8'd50, 8'd60, 8'd70);
        enable = 1'b1; step();
        for (int i = 0; i < 14; i++) begin
            ADC = vec[i];
            step();
        end
        chk("pre_rst_led_red", 32'(LED_RED), 32'd1);
        rst = 1'b1; enable = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("mid_rst_led",   32'({LED_RED, LED_IR}), 32'd0);
        chk("mid_rst_pga",   32'(PGA_Gain), 32'd0);
        chk("mid_rst_dc",    32'(DC_Comp),  32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ovr",   32'(overrun),   32'd0);
        chk("mid_rst_vals",  32'({AMB_ADC_Value, RED_ADC_Value, IR_ADC_Value}), 32'd0);
        for (int i = 0; i < 20; i++) step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Fresh frame after reset: accumulator and shadow config restart cleanly
        fill(8'd20, 8'd200, 8'd150);
        exp_red_pga = 4'd9;
        enable = 1'b1; step();
        run_frame();
        chk_vals("after_rst", 8'd20, 8'd200, 8'd150);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_phase_scheduler.md
LED_PHASE_SCHEDULER -- requirements
Module: led_phase_scheduler

Interface
REQ-001 Parameter SETTLE, default 2: blanking cycles at the start of each phase; ADC samples in these cycles are discarded.
REQ-002 Parameter AVG_LOG2, default 3: log2 of the number of samples averaged per phase; PHASE_LEN = SETTLE + 2^AVG_LOG2 (default 10).
REQ-003 CLK  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  run request; sampled only in IDLE and at frame end.
REQ-006 ADC  in  8  ADC code, valid every cycle.
REQ-007 cfg_red_pga / cfg_ir_pga  in  4 each  PGA gain settings for the RED and IR phases.
REQ-008 cfg_red_dc / cfg_ir_dc  in  7 each  DC compensation settings for the RED and IR phases.
REQ-009 out_ready  in  1  consumer accepts the result triple.
REQ-010 LED_RED / LED_IR  out  1 each  LED enables (registered).
REQ-011 PGA_Gain  out  4; DC_Comp  out  7: front-end settings (registered).
REQ-012 AMB_ADC_Value / RED_ADC_Value / IR_ADC_Value  out  8 each  per-phase averages.
REQ-013 out_valid  out  1; overrun  out  1 (sticky).

Function
REQ-014 FSM states: IDLE, AMB, RED, IR; a frame is AMB->RED->IR, each phase lasting PHASE_LEN cycles.
REQ-015 IDLE with enable=1 shall enter AMB at the next edge with phase_cnt=0; at IR end, enable=1 shall go to AMB and enable=0 to IDLE; enable is ignored mid-frame.
REQ-016 Outputs shall update on the same edge as the state: AMB gives LED_RED=0, LED_IR=0, PGA_Gain=0, DC_Comp=0; RED gives LED_RED=1 with the RED config; IR gives LED_IR=1 with the IR config; IDLE has all four at 0.
REQ-017 phase_cnt counts 0..PHASE_LEN-1 and wraps to 0 on the state advance.
REQ-018 On each edge where phase_cnt ≥ SETTLE, ADC shall be added into an (8+AVG_LOG2)-bit accumulator with no overflow possible.
REQ-019 At the edge where phase_cnt = PHASE_LEN-1, the phase result (acc+ADC)>>AVG_LOG2 (truncating) shall be latched and the accumulator cleared.
REQ-020 The four cfg_* inputs shall be captured into shadow registers only on entry to AMB; changes mid-frame take effect in the next frame.
REQ-021 At the IR-end edge, if out_valid=0 or out_ready=1, all three value outputs shall load together and out_valid shall be set, visible on the cycle after the last IR sample.
REQ-022 out_valid shall stay high with the values stable until out_valid and out_ready are both high at an edge; it then clears unless REQ-021 reloads it on the same edge (back-to-back).
REQ-023 At IR end with out_valid=1 and out_ready=0, the new frame shall be dropped, the old values held, and overrun set to 1; overrun clears only on reset.
REQ-024 Sample results for the current phase shall be held internally until IR end; the value outputs never expose a partial frame.

Reset
REQ-025 rst=1 at any edge, including mid-phase, shall force state IDLE, phase_cnt 0, accumulator 0, shadow config 0, and every output 0 on the next cycle.
REQ-026 After rst is released, operation shall restart only via REQ-015.

Structure
REQ-027 A shared package shall hold the state encoding, the default SETTLE/AVG_LOG2 values, and the width constants (ADC 8, PGA 4, DC 7).
REQ-028 A single sub-module, phase_averager (accumulate, shift, clear), is natural; the FSM, config shadow and output handshake stay in the top level.

Verification (defaults; enable rises at cycle 0)
REQ-029 Per-phase constants: ADC=20 in AMB, 200 in RED, 150 in IR, out_ready=1 -> out_valid pulses at cycle 31 with AMB=20, RED=200, IR=150.
REQ-030 Settling discard: ADC=255 on phase_cnt 0-1, 100 otherwise -> all values = 100.
REQ-031 Truncation: RED samples 0..7 (sum 28) -> RED_ADC_Value = 3.
REQ-032 Backpressure: out_ready=0 for two frames -> first-frame values held, overrun=1 after the second IR end; out_ready=1 -> out_valid clears and overrun stays 1.
REQ-033 Config timing: cfg_red_pga 5->9 during RED of frame 1 -> PGA_Gain=5 for that frame and 9 in frame 2's RED phase.
REQ-034 Reset mid-RED: rst at phase_cnt=4 -> all outputs 0 next cycle, state IDLE, no out_valid.
